// File: rtl/spi_sclk_gen.sv
// Master-mode SPI serial clock generator: divides PCLK by a latched baud divisor,
// drives SCLK with the latched CPOL/CPHA and strobes the shift/sample edges.
module spi_sclk_gen #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PRE_W     = 3,
    parameter int unsigned RATE_W    = 3
) (
    input  logic                              PCLK,
    input  logic                              PRESETn,
    input  logic                              mstr,
    input  logic                              spi_busy,
    input  logic                              cpol,
    input  logic                              cpha,
    input  logic [PRE_W-1:0]                  sppr,
    input  logic [RATE_W-1:0]                 spr,
    output logic                              sclk,
    output logic                              shift_event,
    output logic                              sample_event,
    output logic [$clog2(2*DATA_BITS):0]      edge_count
);

    localparam int unsigned EDGES = 2 * DATA_BITS;
    localparam int unsigned EC_W  = $clog2(EDGES) + 1;
    // Largest half period is 2^PRE_W << (2^RATE_W - 1), which fits in this width.
    localparam int unsigned CNT_W = PRE_W + (1 << RATE_W);

    logic              active_c;
    logic              start_c;
    logic [CNT_W-1:0]  half_m1_c;

    logic              active_q,  active_d;
    logic              sclk_q,    sclk_d;
    logic              shift_q,   shift_d;
    logic              sample_q,  sample_d;
    logic [EC_W-1:0]   ec_q,      ec_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              cpol_l_q,  cpol_l_d;
    logic              cpha_l_q,  cpha_l_d;
    logic [PRE_W-1:0]  sppr_l_q,  sppr_l_d;
    logic [RATE_W-1:0] spr_l_q,   spr_l_d;

    assign active_c  = mstr & spi_busy;
    assign start_c   = active_c & ~active_q;
    assign half_m1_c = CNT_W'((CNT_W'(sppr_l_q) + CNT_W'(1)) << spr_l_q) - CNT_W'(1);

    // Next-state: idle/abort, start-of-transfer latch, or divided edge generation.
    always_comb begin
        active_d = active_c;
        sclk_d   = sclk_q;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        ec_d     = ec_q;
        cnt_d    = cnt_q;
        cpol_l_d = cpol_l_q;
        cpha_l_d = cpha_l_q;
        sppr_l_d = sppr_l_q;
        spr_l_d  = spr_l_q;

        if (!active_c) begin
            sclk_d = cpol;
            cnt_d  = '0;
        end else if (start_c) begin
            cpol_l_d = cpol;
            cpha_l_d = cpha;
            sppr_l_d = sppr;
            spr_l_d  = spr;
            sclk_d   = cpol;
            cnt_d    = '0;
            ec_d     = '0;
        end else if (ec_q < EC_W'(EDGES)) begin
            if (cnt_q == half_m1_c) begin
                cnt_d  = '0;
                sclk_d = ~sclk_q;
                ec_d   = ec_q + EC_W'(1);
                // Even count before the edge means this is a leading (odd) edge.
                if (ec_q[0] == 1'b0) begin
                    shift_d  = cpha_l_q;
                    sample_d = ~cpha_l_q;
                end else begin
                    shift_d  = ~cpha_l_q;
                    sample_d = cpha_l_q;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            ec_q     <= '0;
            cnt_q    <= '0;
            cpol_l_q <= 1'b0;
            cpha_l_q <= 1'b0;
            sppr_l_q <= '0;
            spr_l_q  <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            ec_q     <= ec_d;
            cnt_q    <= cnt_d;
            cpol_l_q <= cpol_l_d;
            cpha_l_q <= cpha_l_d;
            sppr_l_q <= sppr_l_d;
            spr_l_q  <= spr_l_d;
        end
    end

    assign sclk         = sclk_q;
    assign shift_event  = shift_q;
    assign sample_event = sample_q;
    assign edge_count   = ec_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Scoreboard bench for spi_sclk_gen: stimulus queues expected strobes, a monitor
// pops and checks each strobe the DUT presents.
module tb_spi_sclk_gen;

    logic       PCLK;
    logic       PRESETn;
    logic       mstr;
    logic       spi_busy;
    logic       cpol;
    logic       cpha;
    logic [2:0] sppr;
    logic [2:0] spr;
    logic       sclk;
    logic       shift_event;
    logic       sample_event;
    logic [4:0] edge_count;

    spi_sclk_gen #(.DATA_BITS(8), .PRE_W(3), .RATE_W(3)) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .mstr         (mstr),
        .spi_busy     (spi_busy),
        .cpol         (cpol),
        .cpha         (cpha),
        .sppr         (sppr),
        .spr          (spr),
        .sclk         (sclk),
        .shift_event  (shift_event),
        .sample_event (sample_event),
        .edge_count   (edge_count)
    );

    typedef struct {
        int cyc;
        bit is_shift;
        int ec;
        bit sclk;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc++;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    // Resume just after posedge number c.
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // Begin a transfer on the next posedge and queue the first nev expected strobes.
    task automatic start_xfer(input bit pol, input bit pha, input int pre, input int rate,
                              input int nev, output int t0, output int half);
        cpol     = pol;
        cpha     = pha;
        sppr     = 3'(pre);
        spr      = 3'(rate);
        spi_busy = 1'b1;
        t0       = cyc + 1;
        half     = (pre + 1) << rate;
        for (int n = 1; n <= nev; n++) begin
            exp_t e;
            e.cyc      = t0 + n * half;
            e.is_shift = (n % 2 == 1) ? pha : !pha;
            e.ec       = n;
            e.sclk     = pol ^ (n % 2 == 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic finish_xfer(input int t0, input int half, input bit pol);
        wait_until(t0 + 16 * half + 4);
        chk("end_sclk", int'(sclk), int'(pol));
        chk("end_edge_count", int'(edge_count), 16);
        spi_busy = 1'b0;
        wait_until(cyc + 2);
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge PCLK) begin
        if (shift_event || sample_event) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: shift=%0d sample=%0d ec=%0d at cyc %0d, none expected",
                         shift_event, sample_event, edge_count, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (cyc != e.cyc || shift_event != e.is_shift || sample_event != !e.is_shift ||
                    int'(edge_count) != e.ec || sclk != e.sclk) begin
                    errors++;
                    $display("FAIL strobe_%0d: got cyc=%0d shift=%0d sample=%0d ec=%0d sclk=%0d expected cyc=%0d shift=%0d sample=%0d ec=%0d sclk=%0d",
                             e.ec, cyc, shift_event, sample_event, edge_count, sclk,
                             e.cyc, e.is_shift, !e.is_shift, e.ec, e.sclk);
                end
            end
        end
    end

    initial begin
        int t0;
        int half;
        mstr     = 1'b1;
        spi_busy = 1'b0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        sppr     = 3'd0;
        spr      = 3'd0;
        PRESETn  = 1'b1;
        #1 PRESETn = 1'b0;
        #2;
        chk("reset_sclk", int'(sclk), 0);
        chk("reset_strobes", int'({shift_event, sample_event}), 0);
        chk("reset_edge_count", int'(edge_count), 0);
        wait_until(2);
        PRESETn = 1'b1;
        wait_until(4);

        // Basic divide, half = 4
        start_xfer(1'b0, 1'b0, 1, 1, 16, t0, half);
        wait_until(t0);
        chk("start_edge_count", int'(edge_count), 0);
        finish_xfer(t0, half, 1'b0);

        // Idle sclk follows live cpol one cycle later, then cpol=1/cpha=1, half = 1
        cpol = 1'b1;
        wait_until(cyc + 1);
        chk("idle_sclk_follows_cpol", int'(sclk), 1);
        start_xfer(1'b1, 1'b1, 0, 0, 16, t0, half);
        finish_xfer(t0, half, 1'b1);

        // Config change after edge 3 is ignored until the next start
        start_xfer(1'b0, 1'b0, 0, 1, 16, t0, half);
        wait_until(t0 + 3 * half);
        sppr = 3'd7;
        finish_xfer(t0, half, 1'b0);
        start_xfer(1'b0, 1'b0, 7, 1, 16, t0, half);
        finish_xfer(t0, half, 1'b0);

        // Abort after edge 5 while sclk is high, then a full restart
        start_xfer(1'b0, 1'b0, 1, 1, 5, t0, half);
        wait_until(t0 + 5 * half);
        chk("abort_sclk_high_before", int'(sclk), 1);
        spi_busy = 1'b0;
        wait_until(t0 + 5 * half + 1);
        chk("abort_sclk", int'(sclk), 0);
        chk("abort_edge_count_held", int'(edge_count), 5);
        wait_until(cyc + 3);
        start_xfer(1'b0, 1'b0, 1, 1, 16, t0, half);
        wait_until(t0);
        chk("restart_edge_count", int'(edge_count), 0);
        finish_xfer(t0, half, 1'b0);

        // Async reset right after edge 9
        start_xfer(1'b0, 1'b0, 0, 1, 9, t0, half);
        wait_until(t0 + 9 * half);
        @(negedge PCLK);
        #2;
        PRESETn  = 1'b0;
        spi_busy = 1'b0;
        cpol     = 1'b1;
        #1;
        chk("arst_sclk", int'(sclk), 0);
        chk("arst_strobes", int'({shift_event, sample_event}), 0);
        chk("arst_edge_count", int'(edge_count), 0);
        wait_until(cyc + 2);
        PRESETn = 1'b1;
        chk("arst_sclk_before_clock", int'(sclk), 0);
        wait_until(cyc + 1);
        chk("arst_sclk_after_release", int'(sclk), 1);
        wait_until(cyc + 5);
        start_xfer(1'b1, 1'b0, 0, 0, 16, t0, half);
        finish_xfer(t0, half, 1'b1);

        // Maximum divisor, half = 1024, with cpha=1
        start_xfer(1'b0, 1'b1, 7, 7, 16, t0, half);
        finish_xfer(t0, half, 1'b0);

        wait_until(cyc + 4);
        chk("missing_strobes", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
- Master-mode serial clock generator for the SPI block.
- Divides PCLK by a programmable baud divisor and drives SCLK with the selected CPOL/CPHA.
- Emits single-PCLK-cycle shift_event and sample_event strobes aligned to the SCLK edges.
- Sits directly upstream of the master SS/transfer controller. It runs while that controller reports spi_busy, and its shift_event drives the controller's bit counter.

Parameters:
DATA_BITS, 8, bits per transfer; SCLK edges per transfer = 2*DATA_BITS
PRE_W, 3, width of sppr prescaler field
RATE_W, 3, width of spr rate field

Ports:
PCLK  input  1  APB clock
PRESETn  input  1  async active-low reset
mstr  input  1  master mode enable
spi_busy  input  1  transfer in progress (from SS/transfer controller)
cpol  input  1  SCLK idle level
cpha  input  1  clock phase select
sppr  input  PRE_W  baud prescaler select
spr  input  RATE_W  baud rate select
sclk  output  1  serial clock to pad
shift_event  output  1  one-cycle strobe: SCLK edge on which TX data shifts out
sample_event  output  1  one-cycle strobe: SCLK edge on which RX data is sampled
edge_count  output  $clog2(2*DATA_BITS)+1  SCLK edges issued in current transfer

Behaviour:
- Reset and clocking: reset is PRESETn, asynchronous, active-low; clock is PCLK. All outputs are registered.
- Reset values: sclk=0, shift_event=0, sample_event=0, edge_count=0, div counter=0, latched config=0, active_d=0.
- Active condition: active = mstr & spi_busy. active_d is the registered copy of active.
- Start cycle: the PCLK edge where active=1 and active_d=0.
  - Latch cpol, cpha, sppr, spr into shadow registers.
  - Clear div counter and edge_count. No SCLK edge occurs on this cycle.
  - Config inputs are ignored for the rest of the transfer.
- Half period: half = (sppr_l+1) << spr_l PCLK cycles. Range 1..1024; counter is 11 bits, no overflow possible.
- Running (active=1, not start cycle, edge_count < 2*DATA_BITS):
  - Div counter increments each PCLK.
  - When counter == half-1: counter <= 0, sclk <= ~sclk, edge_count <= edge_count+1, and exactly one event strobe fires in that same cycle.
  - Edges therefore land at T0+n*half for n = 1..2*DATA_BITS, where T0 is the start cycle.
- Edge classification: odd edges (1,3,..) are leading; even edges (2,4,..) are trailing.
  - cpha=0: leading edge -> sample_event, trailing edge -> shift_event.
  - cpha=1: leading edge -> shift_event, trailing edge -> sample_event.
  - shift_event and sample_event are never high in the same cycle.
- Exactly DATA_BITS shift_events and DATA_BITS sample_events are issued per transfer.
- After edge 2*DATA_BITS:
  - sclk equals cpol_l; counter holds; no further edges or strobes until a new start cycle.
  - edge_count holds at 2*DATA_BITS.
- Idle (active=0): sclk <= cpol (live input, registered; follows a cpol change 1 cycle later). Counter=0, strobes=0, edge_count held.
- Abort (spi_busy or mstr drops mid-transfer): on the next PCLK edge, sclk <= cpol, counter cleared, strobes low. A strobe is never issued on the cycle active is sampled low.
- Restart: spi_busy low for at least 1 cycle and then high is a new start cycle with fresh config latch.
- Async reset mid-transfer: all state returns to reset values immediately. sclk=0 until the first clock after reset release, then follows cpol.

Test Plan:
- Basic divide: cpol=0, cpha=0, sppr=1, spr=1 (half=4), spi_busy high for 80 cycles -> sclk period 8 PCLK, 16 edges, last edge at T0+64. sample_event at T0+4,12,..,60; shift_event at T0+8,16,..,64. sclk=0 afterwards, edge_count=16.
- Phase/polarity: cpol=1, cpha=1, sppr=0, spr=0 (half=1) -> sclk idles 1, falls at T0+1. shift_event on odd edges, 8 of each strobe, sclk=1 after T0+16.
- Max divisor: sppr=7, spr=7 -> half=1024, first edge at T0+1024, 16th at T0+16384, no counter wrap.
- Config change mid-transfer: sppr changes 0->7 after edge 3 -> spacing stays at the latched half. The new value takes effect only on the next start cycle.
- Abort: spi_busy drops after edge 5 with cpol=0, sclk=1 -> sclk=0 next cycle, no strobes. Re-assert -> edge_count restarts at 0, full 16 edges.
- Async reset mid-transfer at edge 9 -> sclk, strobes and edge_count=0 within the same cycle, and no strobe after release until spi_busy re-rises.
